// File: rtl/single_cpu_pkg.sv
// Shared definitions for the 16-bit single-cycle CPU:
// word width, instruction field positions and opcodes.
package single_cpu_pkg;

  localparam int XLEN   = 16;
  localparam int FW     = 4;
  localparam int OP_LSB = 12;
  localparam int RS_LSB = 8;
  localparam int RT_LSB = 4;
  localparam int RD_LSB = 0;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLT  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_ADDI = 4'h8,
    OP_LW   = 4'h9,
    OP_SW   = 4'hA,
    OP_BEQ  = 4'hB,
    OP_BNE  = 4'hC,
    OP_J    = 4'hD,
    OP_NOP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  function automatic word_t sext4(input logic [3:0] v);
    return {{(XLEN-4){v[3]}}, v};
  endfunction

endpackage

// File: rtl/single_cpu_if.sv
// Operand/result bundle between the CPU datapath
// and its ALU.
interface single_cpu_if;
  single_cpu_pkg::opcode_e op;
  single_cpu_pkg::word_t   a;
  single_cpu_pkg::word_t   b;
  single_cpu_pkg::word_t   y;

  modport master (output op, a, b, input y);
  modport slave  (input op, a, b, output y);
endinterface

// File: rtl/single_cpu_alu.sv
// Combinational ALU; memory ops add the offset,
// branches subtract for the compare.
module single_cpu_alu
  import single_cpu_pkg::*;
(
  single_cpu_if.slave alu
);

  always_comb begin
    alu.y = '0;
    unique case (alu.op)
      OP_ADD, OP_ADDI,
      OP_LW, OP_SW:     alu.y = alu.a + alu.b;
      OP_SUB, OP_BEQ,
      OP_BNE:           alu.y = alu.a - alu.b;
      OP_AND:           alu.y = alu.a & alu.b;
      OP_OR:            alu.y = alu.a | alu.b;
      OP_XOR:           alu.y = alu.a ^ alu.b;
      OP_SLT:           alu.y = {{(XLEN-1){1'b0}},
                                 $signed(alu.a) < $signed(alu.b)};
      OP_SLL:           alu.y = alu.a << alu.b[3:0];
      OP_SRL:           alu.y = alu.a >> alu.b[3:0];
      default:          alu.y = alu.a + alu.b;
    endcase
  end

endmodule

// File: rtl/single_cpu.sv
// Single-cycle 16-bit CPU: PC, ROM, register file
// and data memory; execute in single_cpu_alu.
module single_cpu
  import single_cpu_pkg::*;
#(
  parameter     IMEM_INIT  = "instructions.mem",
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic     CLK,
  input  logic     RESET,
  output logic [3:0] op,
  output logic [3:0] rs,
  output logic [3:0] rt,
  output logic [3:0] rd,
  output word_t    ReadData1,
  output word_t    ReadData2,
  output word_t    WriteData,
  output word_t    DataOut,
  output word_t    currentAddress,
  output word_t    result
);

  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  word_t r_imem [IMEM_DEPTH];
  word_t r_dmem [DMEM_DEPTH];
  word_t r_regs [16];
  word_t r_pc;

  word_t          w_instr;
  word_t          w_imm;
  word_t          w_pc1;
  word_t          w_pc_nxt;
  logic [IAW-1:0] w_iaddr;
  logic [DAW-1:0] w_daddr;
  opcode_e        w_op;
  logic           w_rtype;
  logic           w_imm_op;
  logic           w_we;
  logic           w_take;
  logic [3:0]     w_waddr;

  single_cpu_if w_alu ();

  single_cpu_alu u_alu (.alu(w_alu));

  assign w_iaddr = IAW'(32'(r_pc) % 32'(IMEM_DEPTH));
  assign w_instr = r_imem[w_iaddr];

  assign op = w_instr[OP_LSB +: FW];
  assign rs = w_instr[RS_LSB +: FW];
  assign rt = w_instr[RT_LSB +: FW];
  assign rd = w_instr[RD_LSB +: FW];
  assign w_op = opcode_e'(op);

  assign ReadData1 = r_regs[rs];
  assign ReadData2 = r_regs[rt];
  assign w_imm     = sext4(rd);
  assign w_imm_op  = w_op inside {OP_ADDI, OP_LW, OP_SW};

  assign w_alu.op = w_op;
  assign w_alu.a  = ReadData1;
  assign w_alu.b  = w_imm_op ? w_imm : ReadData2;
  assign result   = w_alu.y;

  // Memory reads are unconditional, so DataOut tracks result
  assign w_daddr   = DAW'(32'(result) % 32'(DMEM_DEPTH));
  assign DataOut   = r_dmem[w_daddr];
  assign WriteData = (w_op == OP_LW) ? DataOut : result;

  assign w_rtype = ~op[3];
  assign w_we    = w_rtype | (w_op == OP_ADDI) | (w_op == OP_LW);
  assign w_waddr = w_rtype ? rd : rt;

  assign w_take =
    ((w_op == OP_BEQ) & (ReadData1 == ReadData2)) |
    ((w_op == OP_BNE) & (ReadData1 != ReadData2));

  assign w_pc1          = r_pc + 16'd1;
  assign currentAddress = r_pc;

  always_comb begin
    w_pc_nxt = w_pc1;
    unique case (1'b1)
      (w_op == OP_HALT): w_pc_nxt = r_pc;
      (w_op == OP_J):    w_pc_nxt = {r_pc[15:12], w_instr[11:0]};
      w_take:            w_pc_nxt = w_pc1 + w_imm;
      default:           ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_pc <= '0;
    else        r_pc <= w_pc_nxt;
  end

  // r0 is never written, so it stays at its reset value of zero
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else if (w_we && (w_waddr != 4'd0)) begin
      r_regs[w_waddr] <= WriteData;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && (w_op == OP_SW)) r_dmem[w_daddr] <= ReadData2;
  end

endmodule

// File: tb/tb_single_cpu.sv
// Bench for single_cpu: directed programs plus random
// programs checked every cycle against an ISA-level model.
module tb_single_cpu;

  localparam int ID = 256;
  localparam int DD = 256;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [3:0]  op, rs, rt, rd;
  logic [15:0] ReadData1, ReadData2, WriteData;
  logic [15:0] DataOut, currentAddress, result;

  single_cpu #(
    .IMEM_INIT (""),
    .IMEM_DEPTH(ID),
    .DMEM_DEPTH(DD)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .op            (op),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .WriteData     (WriteData),
    .DataOut       (DataOut),
    .currentAddress(currentAddress),
    .result        (result)
  );

  always #5 CLK = ~CLK;

  logic [15:0] m_imem [ID];
  logic [15:0] m_dmem [DD];
  logic [15:0] m_regs [16];
  logic [15:0] m_pc;
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  function automatic logic [15:0] sx(input logic [3:0] v);
    return {{12{v[3]}}, v};
  endfunction

  // ISA semantics of the ALU-producing opcodes
  function automatic logic [15:0] isa_val(input logic [3:0] o,
                                          input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [3:0] imm);
    case (o)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return (shortint'(a) < shortint'(b)) ? 16'd1 : 16'd0;
      4'h6: return a << b[3:0];
      4'h7: return a >> b[3:0];
      4'h8, 4'h9, 4'hA: return a + sx(imm);
      default: return 16'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advance
  always @(posedge CLK) begin
    logic [15:0] ins, a, b, r, npc;
    logic [3:0] o, s, t, d;
    if (!RESET) begin
      m_pc <= 16'd0;
      for (int i = 0; i < 16; i++) m_regs[i] <= 16'd0;
    end else begin
      ins = m_imem[m_pc % ID];
      {o, s, t, d} = ins;
      a = m_regs[s];
      b = m_regs[t];
      r = isa_val(o, a, b, d);
      npc = m_pc + 16'd1;
      if (o < 4'h8) begin
        if (d != 0) m_regs[d] <= r;
      end else begin
        case (o)
          4'h8: if (t != 0) m_regs[t] <= r;
          4'h9: if (t != 0) m_regs[t] <= m_dmem[r % DD];
          4'hA: m_dmem[r % DD] <= b;
          4'hB: if (a == b) npc = m_pc + 16'd1 + sx(d);
          4'hC: if (a != b) npc = m_pc + 16'd1 + sx(d);
          4'hD: npc = {m_pc[15:12], ins[11:0]};
          4'hF: npc = m_pc;
          default: ;
        endcase
      end
      m_pc <= npc;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge CLK) begin
    logic [15:0] ins, a, b, r, mem;
    if (chk_en) begin
      ins = m_imem[m_pc % ID];
      a = m_regs[ins[11:8]];
      b = m_regs[ins[7:4]];
      r = isa_val(ins[15:12], a, b, ins[3:0]);
      mem = m_dmem[r % DD];
      chk("pc", currentAddress, m_pc);
      chk("instr", {op, rs, rt, rd}, ins);
      chk("rd1", ReadData1, a);
      chk("rd2", ReadData2, b);
      if (ins[15:12] <= 4'hA) begin
        chk("result", result, r);
        chk("dataout", DataOut, mem);
        chk("wdata", WriteData, (ins[15:12] == 4'h9) ? mem : r);
      end
    end
  end

  task automatic put(input int addr, input logic [15:0] w);
    m_imem[addr] = w;
    dut.r_imem[addr] = w;
  endtask

  task automatic load_prog(input logic [15:0] p [10]);
    for (int i = 0; i < ID; i++) put(i, 16'hF000);
    for (int i = 0; i < 10; i++) put(i, p[i]);
  endtask

  task automatic begin_reset();
    @(negedge CLK);
    #1 RESET = 1'b0;
  endtask

  task automatic release_reset();
    repeat (3) begin
      @(negedge CLK);
      chk("rst_pc", currentAddress, 16'h0000);
      chk("rst_rd1", ReadData1, 16'h0000);
      chk("rst_rd2", ReadData2, 16'h0000);
    end
    #1 RESET = 1'b1;
  endtask

  initial begin
    logic [3:0] ro;
    for (int i = 0; i < DD; i++) begin
      m_dmem[i] = 16'd0;
      dut.r_dmem[i] = 16'd0;
    end
    for (int i = 0; i < ID; i++) put(i, 16'hF000);
    @(posedge CLK);
    #1 chk_en = 1'b1;

    // ALU program
    begin_reset();
    load_prog('{16'h8015, 16'h802D, 16'h0123, 16'h1214, 16'h5215,
                16'h0340, 16'hF000, 16'hF000, 16'hF000, 16'hF000});
    release_reset();
    repeat (2) @(negedge CLK);
    chk("alu_add", result, 16'h0002);
    @(negedge CLK);
    chk("alu_sub", result, 16'hFFF8);
    @(negedge CLK);
    chk("alu_slt", result, 16'h0001);
    @(negedge CLK);
    chk("alu_r3", ReadData1, 16'h0002);
    chk("alu_r4", ReadData2, 16'hFFF8);
    chk("model_r5", m_regs[5], 16'h0001);

    // Store then load
    begin_reset();
    load_prog('{16'h8017, 16'hA012, 16'h9062, 16'h0600, 16'hF000,
                16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000});
    release_reset();
    repeat (2) @(negedge CLK);
    chk("lw_dataout", DataOut, 16'h0007);
    chk("lw_wdata", WriteData, 16'h0007);
    @(negedge CLK);
    chk("lw_r6", ReadData1, 16'h0007);

    // Branches, then HALT at 9
    begin_reset();
    load_prog('{16'hE000, 16'hE000, 16'hE000, 16'hB002, 16'hE000,
                16'hE000, 16'hC002, 16'hE000, 16'hE000, 16'hF000});
    release_reset();
    repeat (3) @(negedge CLK);
    chk("beq_at", currentAddress, 16'd3);
    @(negedge CLK);
    chk("beq_taken", currentAddress, 16'd6);
    @(negedge CLK);
    chk("bne_fall", currentAddress, 16'd7);
    repeat (2) @(negedge CLK);
    chk("halt_at", currentAddress, 16'd9);
    repeat (10) begin
      @(negedge CLK);
      chk("halt_hold", currentAddress, 16'd9);
    end
    begin_reset();
    @(negedge CLK);
    chk("halt_rst", currentAddress, 16'd0);

    // Writes to r0 are dropped
    load_prog('{16'h8001, 16'h0001, 16'h0100, 16'hF000, 16'hF000,
                16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000});
    release_reset();
    chk("r0_result", result, 16'h0001);
    @(negedge CLK);
    chk("r0_read", ReadData1, 16'h0000);
    @(negedge CLK);
    chk("r1_zero", ReadData1, 16'h0000);

    // PC wraps through 0xFFFF
    begin_reset();
    load_prog('{16'hB00E, 16'hF000, 16'hF000, 16'hF000, 16'hF000,
                16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000});
    put(ID - 1, 16'hE000);
    release_reset();
    @(negedge CLK);
    chk("wrap_ffff", currentAddress, 16'hFFFF);
    @(negedge CLK);
    chk("wrap_0000", currentAddress, 16'h0000);

    // Random programs; each reset lands mid-instruction
    for (int p = 0; p < 6; p++) begin
      begin_reset();
      for (int i = 0; i < ID; i++) begin
        ro = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        put(i, {ro, 12'($urandom)});
      end
      for (int i = 0; i < DD; i++) begin
        m_dmem[i] = 16'($urandom);
        dut.r_dmem[i] = m_dmem[i];
      end
      release_reset();
      repeat (400) @(negedge CLK);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
